// File: rtl/text_scanout_if.sv
// Bus bundle between the text scanout engine and its VRAM, font ROM,
// cursor comparator and video sink.
interface text_scanout_if;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [6:0]  char_x;
  logic [4:0]  char_y;
  logic        cursor_active;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        pixel;

  modport master (
    output vram_addr, font_addr,
    output char_x, char_y,
    output hsync, vsync, de, pixel,
    input  vram_data, font_data,
    input  cursor_active
  );

  modport slave (
    input  vram_addr, font_addr,
    input  char_x, char_y,
    input  hsync, vsync, de, pixel,
    output vram_data, font_data,
    output cursor_active
  );
endinterface

// File: rtl/text_scanout.sv
// 80x30 text-mode scanout: VRAM -> font ROM -> serialised pixels,
// with aligned syncs and a blinking two-row underline cursor.
module text_scanout #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int BLINK_FRAMES = 30
) (
  input  logic           clk,
  input  logic           reset,
  text_scanout_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [9:0]    hc_q, hc_d, vc_q, vc_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;

  logic       act1_q, act1_d, act2_q, act2_d;
  logic [3:0] grow1_q, grow1_d, grow2_q, grow2_d;
  logic [2:0] bit1_q, bit1_d, bit2_q, bit2_d;
  logic       cur1_q, cur1_d, cur2_q, cur2_d;
  logic       hs1_q, hs1_d, hs2_q, hs2_d;
  logic       vs1_q, vs1_d, vs2_q, vs2_d;

  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic de_q, de_d, pixel_q, pixel_d;

  logic       active;
  logic [6:0] col;
  logic [4:0] row;
  logic       glyph_bit;
  logic       cursor_on;

  always_comb begin
    hc_d    = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
    vc_d    = vc_q;
    frame_d = frame_q;
    blink_d = blink_q;
    if (hc_q == H_LAST) begin
      vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
      if (vc_q == V_LAST) begin
        frame_d = (frame_q == F_LAST) ? '0 : frame_q + FW'(1);
        blink_d = (frame_q == F_LAST) ? ~blink_q : blink_q;
      end
    end
  end

  // Stage 0: cell position drives both VRAM and the cursor comparator
  always_comb begin
    active        = (hc_q < H_ACT) && (vc_q < V_ACT);
    col           = active ? hc_q[9:3] : 7'd0;
    row           = active ? vc_q[8:4] : 5'd0;
    bus.char_x    = col;
    bus.char_y    = row;
    bus.vram_addr = {row, col};
  end

  always_comb begin
    act1_d  = active;
    grow1_d = vc_q[3:0];
    bit1_d  = hc_q[2:0];
    cur1_d  = bus.cursor_active;
    hs1_d   = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
    vs1_d   = !((vc_q >= VS_BEG) && (vc_q <= VS_END));
  end

  // Stage 1: VRAM data is back; blanking cycles present a zero ROM address
  assign bus.font_addr = act1_q ? {bus.vram_data, grow1_q} : 12'd0;

  always_comb begin
    act2_d  = act1_q;
    grow2_d = grow1_q;
    bit2_d  = bit1_q;
    cur2_d  = cur1_q;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
  end

  // Stage 2: glyph bit plus underline overlay
  always_comb begin
    glyph_bit = bus.font_data[3'd7 - bit2_q];
    cursor_on = cur2_q & blink_q & (grow2_q >= 4'd14);
    de_d      = act2_q;
    pixel_d   = act2_q & (glyph_bit | cursor_on);
    hsync_d   = hs2_q;
    vsync_d   = vs2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q    <= '0;
      vc_q    <= '0;
      frame_q <= '0;
      blink_q <= 1'b1;
      act1_q  <= 1'b0;
      act2_q  <= 1'b0;
      grow1_q <= '0;
      grow2_q <= '0;
      bit1_q  <= '0;
      bit2_q  <= '0;
      cur1_q  <= 1'b0;
      cur2_q  <= 1'b0;
      hs1_q   <= 1'b1;
      hs2_q   <= 1'b1;
      vs1_q   <= 1'b1;
      vs2_q   <= 1'b1;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      pixel_q <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      act1_q  <= act1_d;
      act2_q  <= act2_d;
      grow1_q <= grow1_d;
      grow2_q <= grow2_d;
      bit1_q  <= bit1_d;
      bit2_q  <= bit2_d;
      cur1_q  <= cur1_d;
      cur2_q  <= cur2_d;
      hs1_q   <= hs1_d;
      hs2_q   <= hs2_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      pixel_q <= pixel_d;
    end
  end

  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.de    = de_q;
  assign bus.pixel = pixel_q;
endmodule

// File: tb/tb_text_scanout.sv
// Directed bench for text_scanout on a shrunken raster
// (96x71 total, 8x4 cells, 2-frame blink) so every feature fits in a short run.
module tb_text_scanout;
  localparam int HT    = 96;
  localparam int VT    = 71;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic font_mode = 1'b1;
  logic cur_en = 1'b0;
  int   cnt = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  text_scanout_if bus();

  text_scanout #(
    .H_ACTIVE(64), .H_FP(8), .H_SYNC(16), .H_BP(8),
    .V_ACTIVE(64), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // every VRAM cell holds 'A'; the font has one non-blank row
  always @(posedge clk) begin
    bus.vram_data <= 8'h41;
    bus.font_data <= (font_mode && bus.font_addr == 12'h413) ? 8'hA5 : 8'h00;
  end

  assign bus.cursor_active = cur_en && bus.char_x == 7'd5 && bus.char_y == 5'd2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(negedge clk);
    cnt++;
  endtask

  task automatic goto_pos(input int h, input int v);
    int p;
    p = v * HT + h;
    while ((cnt % FRAME) != p) tick1();
  endtask

  // pixels lit over cell 5 of line v (counter offset 3 for latency)
  task automatic cell_ones(input int v, output int ones);
    ones = 0;
    goto_pos(43, v);
    for (int i = 0; i < 8; i++) begin
      if (bus.pixel === 1'b1) ones++;
      tick1();
    end
  endtask

  initial begin
    int hs_low, vs_low, de_hi, de_rises;
    int hs_f1, hs_r1, hs_f2, vs_f, vs_r, de_r1, de_f1;
    logic p_hs, p_vs, p_de;
    logic [7:0] pat;
    logic [11:0] exp_a;
    int ones, fall;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_hsync", bus.hsync, 1);
    chk("rst_vsync", bus.vsync, 1);
    chk("rst_de", bus.de, 0);
    chk("rst_pixel", bus.pixel, 0);
    chk("rst_vram_addr", bus.vram_addr, 0);
    chk("rst_font_addr", bus.font_addr, 0);
    chk("rst_char_x", bus.char_x, 0);
    chk("rst_char_y", bus.char_y, 0);
    reset = 1'b0;
    cnt = 0;

    // sync timing over one frame window
    hs_low = 0; vs_low = 0; de_hi = 0; de_rises = 0;
    hs_f1 = -1; hs_r1 = -1; hs_f2 = -1;
    vs_f = -1; vs_r = -1; de_r1 = -1; de_f1 = -1;
    p_hs = 1'b1; p_vs = 1'b1; p_de = 1'b0;
    for (int i = 1; i <= FRAME; i++) begin
      tick1();
      if (!bus.hsync) hs_low++;
      if (!bus.vsync) vs_low++;
      if (bus.de) de_hi++;
      if (p_hs && !bus.hsync) begin
        if (hs_f1 < 0) hs_f1 = cnt;
        else if (hs_f2 < 0) hs_f2 = cnt;
      end
      if (!p_hs && bus.hsync && hs_r1 < 0) hs_r1 = cnt;
      if (p_vs && !bus.vsync && vs_f < 0) vs_f = cnt;
      if (!p_vs && bus.vsync && vs_r < 0) vs_r = cnt;
      if (!p_de && bus.de) begin
        de_rises++;
        if (de_r1 < 0) de_r1 = cnt;
      end
      if (p_de && !bus.de && de_f1 < 0) de_f1 = cnt;
      p_hs = bus.hsync; p_vs = bus.vsync; p_de = bus.de;
    end
    chk("hsync_low_total", hs_low, 1136);
    chk("vsync_low_total", vs_low, 192);
    chk("de_high_total", de_hi, 4096);
    chk("de_lines", de_rises, 64);
    chk("hsync_fall1", hs_f1, 75);
    chk("hsync_rise1", hs_r1, 91);
    chk("hsync_fall2", hs_f2, 171);
    chk("vsync_fall", vs_f, 6339);
    chk("vsync_rise", vs_r, 6531);
    chk("de_rise1", de_r1, 3);
    chk("de_fall1", de_f1, 67);

    // glyph serialisation, frame 1, cell 2 of line 3
    goto_pos(17, 3);
    chk("font_addr_act", bus.font_addr, 12'h413);
    goto_pos(19, 3);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("glyph_pixel", bus.pixel, pat[7-i]);
      chk("glyph_de", bus.de, 1);
      tick1();
    end
    goto_pos(70, 3);
    chk("font_addr_blank", bus.font_addr, 0);

    // cursor at (5,2), frame 1 (blink on)
    font_mode = 1'b0;
    cur_en = 1'b1;
    cell_ones(30, ones);
    chk("cursor_other_row", ones, 0);
    cell_ones(45, ones);
    chk("cursor_line45", ones, 0);
    goto_pos(42, 46);
    chk("cursor_left_nb", bus.pixel, 0);
    cell_ones(46, ones);
    chk("cursor_line46", ones, 8);
    chk("cursor_right_nb", bus.pixel, 0);
    cell_ones(47, ones);
    chk("cursor_line47", ones, 8);

    // address scan, frame 2
    goto_pos(0, 37);
    for (int h = 0; h < HT; h++) begin
      exp_a = (h < 64) ? {5'd2, 7'(h / 8)} : 12'd0;
      chk("vram_addr_v37", bus.vram_addr, exp_a);
      chk("char_x_v37", bus.char_x, (h < 64) ? h / 8 : 0);
      chk("char_y_v37", bus.char_y, (h < 64) ? 2 : 0);
      tick1();
    end
    cell_ones(46, ones);
    chk("blink_frame2", ones, 0);
    goto_pos(63, 47);
    chk("vram_addr_v47_last", bus.vram_addr, 12'h107);
    goto_pos(0, 48);
    chk("vram_addr_v48", bus.vram_addr, 12'h180);
    chk("char_y_v48", bus.char_y, 3);
    goto_pos(0, 64);
    chk("vram_addr_vblank", bus.vram_addr, 0);

    // blink: frames 3..6
    cell_ones(46, ones);
    chk("blink_frame3", ones, 0);
    cell_ones(46, ones);
    chk("blink_frame4", ones, 8);
    cell_ones(46, ones);
    chk("blink_frame5", ones, 8);
    cell_ones(46, ones);
    chk("blink_frame6", ones, 0);

    // mid-line reset in frame 7 (blink off, frame_cnt 1)
    goto_pos(30, 10);
    chk("pre_reset_de", bus.de, 1);
    chk("pre_reset_blink", dut.blink_q, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_hsync", bus.hsync, 1);
    chk("mid_rst_vsync", bus.vsync, 1);
    chk("mid_rst_de", bus.de, 0);
    chk("mid_rst_pixel", bus.pixel, 0);
    chk("mid_rst_vram_addr", bus.vram_addr, 0);
    chk("mid_rst_blink_on", dut.blink_q, 1);
    chk("mid_rst_frame_cnt", dut.frame_q, 0);
    tick1();
    tick1();
    chk("mid_rst_font_addr", bus.font_addr, 0);
    reset = 1'b0;
    cnt = 0;
    fall = -1;
    p_hs = bus.hsync;
    for (int i = 1; i <= 200 && fall < 0; i++) begin
      tick1();
      if (p_hs && !bus.hsync) fall = cnt;
      p_hs = bus.hsync;
    end
    chk("post_rst_hsync_fall", fall, 75);
    cell_ones(46, ones);
    chk("post_rst_cursor_vis", ones, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/text_scanout.md
# text_scanout

Reads the 80x30 character VRAM and font ROM and produces a 640x480@60 monochrome video stream (hsync, vsync, de, pixel) with a blinking underline cursor. It is the read side of the text VRAM: the keyboard/terminal writer fills VRAM at {row, col}, and this block scans it out. It drives the char_x/char_y position that the writer compares against its cursor, and receives the resulting cursor_active back. It runs entirely in the pixel clock domain.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- reset  in  1  asynchronous, active-high
- vram_addr  out  12  {row[4:0], col[6:0]}; synchronous VRAM read, data valid next cycle
- vram_data  in  8  character code from VRAM
- font_addr  out  12  {char[7:0], glyph_row[3:0]}; synchronous ROM read, data valid next cycle
- font_data  in  8  glyph row bits; bit 7 = leftmost pixel
- char_x  out  7  current cell column, to the cursor comparator
- char_y  out  5  current cell row, to the cursor comparator
- cursor_active  in  1  combinational response to char_x/char_y; high when the cell is the cursor cell
- hsync  out  1  active-low
- vsync  out  1  active-low
- de  out  1  active-video enable
- pixel  out  1  monochrome pixel

## Operation
- Counters:
  - hc counts 0..799 (H total = sum of H params) and wraps to 0.
  - vc increments when hc wraps and itself wraps 524 -> 0.
- Stage 0 (counter cycle):
  - Active region = hc < H_ACTIVE and vc < V_ACTIVE.
  - In active: col = hc[9:3], row = vc[8:4], glyph_row = vc[3:0], bitsel = hc[2:0].
  - char_x = col, char_y = row, vram_addr = {row, col}.
  - Outside active: char_x, char_y and vram_addr are all 0.
  - Sample cursor_active.
- Stage 1: font_addr = {vram_data, glyph_row delayed 1}.
- Stage 2: font_data is valid. Bit selected = font_data[7 - bitsel delayed 2].
- Stage 3 (registered outputs):
  - pixel = de ? (glyph_bit | cursor_on) : 0.
  - cursor_on = cursor_active(delayed 2) & blink_on & (glyph_row(delayed 2) >= 14).
  - The cursor is a two-row underline that OR-s over the glyph.
- Sync decode, delayed 3 cycles to align with pixel:
  - hsync low for hc in [656, 751].
  - vsync low for vc in [490, 491].
  - de = active region.
- Blink:
  - frame_cnt runs 0..BLINK_FRAMES-1 and advances at hc=799, vc=524.
  - On wrap, frame_cnt returns to 0 and blink_on toggles.
- Widths: all address fields are zero-extended slices. No arithmetic beyond the counters.

## Timing
- Reset values:
  - hc=0, vc=0, frame_cnt=0, blink_on=1.
  - hsync=1, vsync=1, de=0, pixel=0.
  - vram_addr=0, font_addr=0, char_x=0, char_y=0.
  - Pipeline registers cleared.
- Reset is asynchronous: outputs take reset values immediately, mid-line or mid-frame. After release, hc advances from 0 on the first rising edge.
- Latency: fixed 3 cycles from the counter value to hsync/vsync/de/pixel. All four outputs are mutually aligned.
- Each VRAM address is held for 8 consecutive cycles, with one new cell per 8 pixels. The VRAM and font read latency is exactly 1 cycle each; no stalls, no handshake.
- cursor_active must settle within the same cycle as char_x/char_y.
- Line period 800 cycles; frame period 420000 cycles. The blink half-period is BLINK_FRAMES frames.
- Boundaries:
  - hc=639 -> 640 ends active video (de falls 3 cycles later).
  - hc=799 with vc=524 wraps both counters and advances frame_cnt in the same edge.
  - Cell row 29 covers lines 464..479; no row 30 address is ever issued.

## Test plan
- Sync timing: after reset release, check on hsync/vsync/de:
  - hsync low for exactly 96 cycles every 800.
  - vsync low for exactly 1600 cycles every 420000.
  - de high for 640 cycles per line on 480 lines per frame.
- Address scan: with a VRAM model, check the vram_addr sequence on a line with vc=37:
  - Each address is held 8 cycles; col runs 0..79; row = 2.
  - vram_addr is 0 during blanking.
  - Row changes at vc=48.
- Glyph serialisation: VRAM returns 0x41 and font returns 0xA5 for {0x41, row 3}. Over one cell at glyph_row 3, pixel = 1,0,1,0,0,1,0,1 with de high.
- Cursor: cursor_active is high only at char_x=5, char_y=2, font_data = 0, blink_on=1.
  - Pixel = 1 for all 8 pixels on lines 46 and 47 of cell (5,2).
  - Pixel = 0 on lines 32..45 and in all other cells.
- Blink: same setup, run 61 frames.
  - Cursor visible in frames 0..29, absent in frames 30..59, visible in frame 60.
- Reset mid-line: assert reset at hc=300, vc=100.
  - hsync=1, vsync=1, de=0, pixel=0 immediately.
  - After release, the first hsync falling edge occurs 656+3 cycles later.
  - blink_on=1 and frame_cnt=0.
